// File: rtl/status_led_sequencer_pkg.sv
// Shared constants and state encoding for the status LED blink-code sequencer.
package status_led_sequencer_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ_HZ = 50000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } led_state_e;

endpackage

// File: rtl/status_led_sequencer.sv
// Blinks a 4-bit fault code on an LED REPEAT times; shows heartbeat when idle.
// Define STATUS_LED_ACTIVE_LOW_EN to drive the LED inverted (including in reset).
module status_led_sequencer
  import status_led_sequencer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = DEFAULT_CLK_FREQ_HZ,
  parameter int unsigned BLINK_ON_MS  = 200,
  parameter int unsigned BLINK_OFF_MS = 200,
  parameter int unsigned GAP_MS       = 1000,
  parameter int unsigned REPEAT       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       heartbeat,
  input  logic       fault_valid,
  input  logic [3:0] fault_code,
  output logic       fault_ready,
  output logic       busy,
  output logic       led,
  output logic [1:0] dbg_state
);

  localparam int unsigned TICKS_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int unsigned ON_CYC       = BLINK_ON_MS * TICKS_PER_MS;
  localparam int unsigned OFF_CYC      = BLINK_OFF_MS * TICKS_PER_MS;
  localparam int unsigned GAP_CYC      = GAP_MS * TICKS_PER_MS;
  localparam int unsigned MAX_A        = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int unsigned MAX_CYC      = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int unsigned CNT_W        = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [3:0]       REP_MAX  = 4'(REPEAT);

`ifdef STATUS_LED_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  led_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       blink_q, blink_d;
  logic [3:0]       rep_q, rep_d;
  logic [3:0]       code_q, code_d;
  logic             led_q, led_d;
  logic             led_raw;

  // Valid/ready: a code transfers on a rising edge where fault_valid && fault_ready;
  // fault_ready is high only in IDLE, so offers made while busy are simply not taken.
  assign fault_ready = (state_q == IDLE);
  assign busy        = ~fault_ready;
  assign led         = led_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blink_q <= '0;
      rep_q   <= '0;
      code_q  <= '0;
      led_q   <= LED_INV;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      rep_q   <= rep_d;
      code_q  <= code_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    rep_d   = rep_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        // Code 0 is consumed here without leaving IDLE.
        if (fault_valid && (fault_code != 4'd0)) begin
          state_d = ON;
          cnt_d   = '0;
          blink_d = 4'd1;
          rep_d   = 4'd1;
          code_d  = fault_code;
        end
      end
      ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d   = '0;
          state_d = (blink_q < code_q) ? OFF : GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      OFF: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d   = '0;
          state_d = ON;
          blink_d = blink_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (rep_q < REP_MAX) begin
            state_d = ON;
            blink_d = 4'd1;
            rep_d   = rep_q + 4'd1;
          end else begin
            state_d = IDLE;
            blink_d = '0;
            rep_d   = '0;
            code_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        blink_d = '0;
        rep_d   = '0;
        code_d  = '0;
      end
    endcase
    // LED is registered from the next state so it lines up with the state it shows.
    led_raw = (state_d == IDLE) ? heartbeat : (state_d == ON);
    led_d   = led_raw ^ LED_INV;
  end

endmodule

// File: doc/status_led_sequencer.md
STATUS_LED_SEQUENCER -- requirements
Module: status_led_sequencer

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50000000: clock frequency; TICKS_PER_MS = CLK_FREQ_HZ/1000, integer division.
REQ-002 Parameter BLINK_ON_MS, default 200: duration of each blink ON phase.
REQ-003 Parameter BLINK_OFF_MS, default 200: LED-off interval between blinks of one code.
REQ-004 Parameter GAP_MS, default 1000: LED-off interval after the last blink of a code.
REQ-005 Parameter REPEAT, default 3, range 1..15: number of times a code is played.
REQ-006 clk  input  1  system clock; all logic on posedge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 heartbeat  input  1  "I'm alive" signal from the heartbeat generator; shown when idle.
REQ-009 fault_valid  input  1  fault code offered.
REQ-010 fault_code  input  4  blink count, 1..15; 0 is a clear request.
REQ-011 fault_ready  output  1  sequencer can accept a code.
REQ-012 busy  output  1  a code sequence is playing.
REQ-013 led  output  1  registered LED drive.

Function
REQ-014 The block SHALL define ON_CYC = BLINK_ON_MS*TICKS_PER_MS, OFF_CYC = BLINK_OFF_MS*TICKS_PER_MS and GAP_CYC = GAP_MS*TICKS_PER_MS, all in clock cycles.
REQ-015 The FSM SHALL have states IDLE, ON, OFF and GAP; fault_ready = (state==IDLE); busy = !fault_ready.
REQ-016 A transfer SHALL occur on a rising edge with fault_valid && fault_ready; fault_code is latched on that edge.
REQ-017 In IDLE, led SHALL equal heartbeat delayed by exactly one cycle.
REQ-018 A transfer with code 0 SHALL be consumed and leave the FSM in IDLE, with no blink.
REQ-019 A transfer with code N>0 SHALL enter ON on the next edge, clear the phase counter, set blink count to 1 and set repeat count to 1.
REQ-020 ON SHALL last exactly ON_CYC cycles with led=1; it then goes to OFF if blink<N, otherwise to GAP.
REQ-021 OFF SHALL last exactly OFF_CYC cycles with led=0, then go to ON with blink+1.
REQ-022 GAP SHALL last exactly GAP_CYC cycles with led=0; it then goes to ON (blink=1, repeat+1) if repeat<REPEAT, otherwise to IDLE.
REQ-023 Each repeat SHALL take N*ON_CYC+(N-1)*OFF_CYC+GAP_CYC cycles; busy SHALL stay high for REPEAT times that.
REQ-024 fault_valid and fault_code SHALL be ignored while busy; there is no queueing, and the upstream holds fault_valid until accepted.
REQ-025 fault_code SHALL have no effect after it is latched, even if it changes.
REQ-026 Phase counters SHALL be sized by $clog2 of the largest cycle constant plus 1 and SHALL never wrap within a phase.

Reset
REQ-027 While reset=0, the block SHALL hold state=IDLE, all counters=0, led=0, busy=0 and fault_ready=1.
REQ-028 Reset asserted mid-sequence SHALL abort the sequence immediately and asynchronously; no resume after release.
REQ-029 The first edge after release SHALL accept a pending fault_valid.

Configuration
REQ-030 With macro STATUS_LED_ACTIVE_LOW_EN defined, the block SHALL drive led inverted in every state and in reset (led=1 during reset).
REQ-031 Without STATUS_LED_ACTIVE_LOW_EN, led SHALL be active-high as in REQ-017 to REQ-027.

Structure
REQ-032 The state enum typedef and the default CLK_FREQ_HZ value SHALL live in the shared global constants package.
REQ-033 The block MAY instance one sub-module, ms_tick_gen, a prescaler that restarts on transfer; cycle-exact phase lengths are mandatory either way.

Verification (CLK_FREQ_HZ=1000, ON=2, OFF=2, GAP=5, REPEAT=2 unless stated)
REQ-034 Idle pass-through: toggle heartbeat each cycle -> led follows with 1-cycle delay; fault_ready=1, busy=0.
REQ-035 Code 3: led sequence 11 00 11 00 11 00000 twice; busy high for exactly 30 cycles; fault_ready back to 1 on cycle 31.
REQ-036 Code 0: fault_ready stays 1, busy never rises, led keeps tracking heartbeat.
REQ-037 Code 15 then code 2 mid-sequence: the second code is ignored; total busy = 2*(30+28+5) = 126 cycles.
REQ-038 Reset pulse during the second ON of code 5 -> led=0 and busy=0 at once; a new code 1 after release plays ON 2 and GAP 5, twice.
REQ-039 Build with STATUS_LED_ACTIVE_LOW_EN and rerun code 3 -> exact inverse of the REQ-035 led waveform; led=1 in reset.
